// File: rtl/clk_div_prog_l_pkg.sv
// Shared constants for the programmable clock divider.
package clk_div_prog_l_pkg;

  // Default width of the divisor port and the half-period counter.
  localparam int unsigned CLK_DIV_W_DEFAULT = 32'd4;

endpackage : clk_div_prog_l_pkg

// File: rtl/clk_div_prog_l.sv
// Programmable clock divider. Each output half-period lasts div+1 input
// cycles. The divisor is captured only on reset and on toggle edges, so a
// half-period in progress always finishes with the divisor it started with.
module clk_div_prog_l
  import clk_div_prog_l_pkg::*;
#(
  parameter int unsigned n = CLK_DIV_W_DEFAULT
) (
  input  logic         in,
  input  logic         rst,
  input  logic [n-1:0] div,
  output logic         out
);

  typedef logic [n-1:0] div_t;

  localparam div_t CNT_ZERO = div_t'(0);
  localparam div_t CNT_ONE  = div_t'(1);

  div_t cnt_r;
  div_t div_l_r;
  logic out_r;

  div_t cnt_nxt_s;
  div_t div_l_nxt_s;
  logic out_nxt_s;
  logic toggle_s;

  // Decide whether this edge ends the half-period and compute next state.
  always_comb begin
    toggle_s    = 1'b0;
    cnt_nxt_s   = cnt_r;
    div_l_nxt_s = div_l_r;
    out_nxt_s   = out_r;
    // ">=" rather than "==" lets a corrupted counter recover within one half.
    if (cnt_r >= div_l_r) begin
      toggle_s    = 1'b1;
      cnt_nxt_s   = CNT_ZERO;
      div_l_nxt_s = div;
      out_nxt_s   = ~out_r;
    end else begin
      toggle_s    = 1'b0;
      cnt_nxt_s   = cnt_r + CNT_ONE;
      div_l_nxt_s = div_l_r;
      out_nxt_s   = out_r;
    end
  end

  // State register; reset wins over toggling and reloads the divisor.
  always_ff @(posedge in) begin
    if (rst) begin
      cnt_r   <= CNT_ZERO;
      div_l_r <= div;
      out_r   <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      div_l_r <= div_l_nxt_s;
      out_r   <= out_nxt_s;
    end
  end

  assign out = out_r;

endmodule : clk_div_prog_l

// File: tb/tb_clk_div_prog_l.sv
// Self-checking bench for clk_div_prog_l (n = 4, in period 10).
// Expected output levels are queued when each edge's stimulus is applied and
// compared just after that edge.
module tb_clk_div_prog_l;

  logic       in;
  logic       rst;
  logic [3:0] div;
  logic       out;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];

  // Reference: cycles remaining in the current half-period and output level.
  int   m_rem = 0;
  logic m_out = 1'b0;

  clk_div_prog_l #(.n(4)) dut (
    .in  (in),
    .rst (rst),
    .div (div),
    .out (out)
  );

  initial begin
    in = 1'b0;
    forever #5 in = ~in;
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: out=%0b expected=%0b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one edge worth of stimulus, predict, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic [3:0] d);
    logic e;
    @(negedge in);
    rst = r;
    div = d;
    if (r) begin
      m_out = 1'b0;
      m_rem = int'(d) + 1;
    end else begin
      m_rem = m_rem - 1;
      if (m_rem <= 0) begin
        m_out = ~m_out;
        m_rem = int'(d) + 1;
      end
    end
    exp_q.push_back(m_out);
    @(posedge in);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, out, ~out);
    end else begin
      e = exp_q.pop_front();
      check(tag, out, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    div = 4'd0;

    // div = 0: toggles every edge.
    step("rst_d0", 1'b1, 4'd0);
    step("rst_d0", 1'b1, 4'd0);
    for (int i = 0; i < 12; i++) step("div0", 1'b0, 4'd0);

    // div = 1: two high, two low; first rise on 2nd edge.
    step("rst_d1", 1'b1, 4'd1);
    for (int i = 0; i < 16; i++) step("div1", 1'b0, 4'd1);

    // div = 2, then 7 mid-half: current half ends at 3, then halves of 8.
    step("rst_d2", 1'b1, 4'd2);
    for (int i = 0; i < 4; i++) step("div2", 1'b0, 4'd2);
    for (int i = 0; i < 40; i++) step("div2to7", 1'b0, 4'd7);

    // div = 15: half-period of 16, no counter wrap.
    step("rst_d15", 1'b1, 4'd15);
    for (int i = 0; i < 70; i++) step("div15", 1'b0, 4'd15);

    // 4 -> 0 mid-half: current half ends at 5, then every-edge toggles.
    step("rst_d4", 1'b1, 4'd4);
    for (int i = 0; i < 2; i++) step("div4", 1'b0, 4'd4);
    for (int i = 0; i < 20; i++) step("div4to0", 1'b0, 4'd0);

    // Reset pulse while out is high mid-half.
    step("rst_d3", 1'b1, 4'd3);
    for (int i = 0; i < 6; i++) step("div3", 1'b0, 4'd3);
    check("high_before_rst", out, 1'b1);
    step("mid_rst", 1'b1, 4'd3);
    check("low_on_rst", out, 1'b0);
    for (int i = 0; i < 12; i++) step("after_rst", 1'b0, 4'd3);

    // Random divisor changes at arbitrary times.
    step("rst_rand", 1'b1, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) div = 4'($urandom_range(0, 15));
      step("rand", 1'b0, div);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_clk_div_prog_l
